// File: rtl/mcu_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and timeout default for the
// instruction fetch/sequencing controller.
package mcu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVI = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_BUBBLE,
    S_HALT,
    S_FAULT
  } state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: load beats increment, increment wraps naturally at all-ones.
module pc_reg #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_next_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_val_i;
    else if (inc_i) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch/issue sequencer: fetches a word, decodes NOP/HALT locally,
// and presents everything else to the execution FSMs with a timeout guard.
module instr_fetch_ctrl
  import mcu_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [15:0]       memData,
  output logic [15:0]       instruction,
  input  logic              pcInc,
  input  logic              done,
  input  logic              pcLoad,
  input  logic [ADDR_W-1:0] pcLoadVal,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pc_inc, pc_ld;
  logic [ADDR_W-1:0] pc_next;

  logic              memReq_q, halted_q, fault_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [15:0]       instr_q;

  pc_reg #(.ADDR_W(ADDR_W)) u_pc (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (pc_inc),
    .load_i     (pc_ld),
    .load_val_i (pcLoadVal),
    .pc_o       (pc),
    .pc_next_o  (pc_next)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: if (memAck) begin
        ir_d    = memData;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        case (ir_q[15:12])
          OP_NOP: begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            cnt_d   = '0;
            state_d = S_EXEC;
          end
        endcase
      end
      S_EXEC: begin
        pc_inc = pcInc;
        pc_ld  = pcLoad;
        // done in the last allowed cycle still counts as a clean finish
        if (done)                  state_d = S_BUBBLE;
        else if (cnt_q == CNT_LAST) state_d = S_FAULT;
        else                       cnt_d   = cnt_q + CNT_W'(1);
      end
      S_BUBBLE: state_d = run ? S_FETCH : S_IDLE;
      default: ;
    endcase
  end

  // Outputs are registered from next-state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      cnt_q     <= '0;
      memReq_q  <= 1'b0;
      memAddr_q <= '0;
      instr_q   <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      memReq_q <= (state_d == S_FETCH);
      if (state_d == S_FETCH) memAddr_q <= pc_next;
      instr_q  <= (state_d == S_EXEC) ? ir_d : 16'h0000;
      halted_q <= (state_d == S_HALT);
      fault_q  <= (state_d == S_FAULT);
    end
  end

  assign memReq      = memReq_q;
  assign memAddr     = memAddr_q;
  assign instruction = instr_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench: the bench plays memory and execution FSMs, tracking the
// expected PC and output words from the sequencing rules at instruction level.
module tb_instr_fetch_ctrl;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst, run, memReq, memAck, pcInc, done, pcLoad, halted, fault;
  logic [ADDR_W-1:0] memAddr, pcLoadVal, pc;
  logic [15:0]       memData, instruction;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_pc  = 0;
  logic [15:0] mem [256];

  instr_fetch_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .memReq      (memReq),
    .memAddr     (memAddr),
    .memAck      (memAck),
    .memData     (memData),
    .instruction (instruction),
    .pcInc       (pcInc),
    .done        (done),
    .pcLoad      (pcLoad),
    .pcLoadVal   (pcLoadVal),
    .pc          (pc),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; memAck = 1'b0; pcInc = 1'b0; pcLoad = 1'b0; done = 1'b0;
    tick();
    rst = 1'b0;
    exp_pc = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_instr"},  instruction, 0);
    chk({tag, "_req"},    memReq, 0);
    chk({tag, "_addr"},   memAddr, 0);
    chk({tag, "_pc"},     pc, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_fault"},  fault, 0);
  endtask

  // Called in a FETCH cycle; returns once the DUT is in ISSUE.
  task automatic fetch(input int lat, input bit noise, output logic [15:0] w);
    chk("fetch_req", memReq, 1);
    chk("fetch_addr", memAddr, exp_pc);
    for (int i = 0; i < lat; i++) begin
      pcInc = noise; pcLoad = noise; pcLoadVal = 8'h33; done = noise;
      tick();
      pcInc = 1'b0; pcLoad = 1'b0; done = 1'b0;
      chk("wait_req", memReq, 1);
      chk("wait_addr", memAddr, exp_pc);
      chk("wait_pc", pc, exp_pc);
    end
    w = mem[exp_pc];
    memAck = 1'b1; memData = w;
    tick();
    memAck = 1'b0; memData = 16'hDEAD;
    chk("issue_req", memReq, 0);
  endtask

  task automatic issue(input logic [15:0] w);
    tick();
    if (w[15:12] == 4'h0) begin
      exp_pc = (exp_pc + 1) & 255;
      chk("nop_pc", pc, exp_pc);
      chk("nop_instr", instruction, 0);
    end else if (w[15:12] == 4'hF) begin
      chk("halt_flag", halted, 1);
      chk("halt_req", memReq, 0);
      chk("halt_instr", instruction, 0);
    end else begin
      chk("exec_entry", instruction, w);
      chk("exec_fault", fault, 0);
    end
  endtask

  task automatic exec_cycle(input logic [15:0] w, input bit inc, input bit ld,
                            input logic [7:0] val, input bit dn);
    chk("exec_instr", instruction, w);
    pcInc = inc; pcLoad = ld; pcLoadVal = val; done = dn;
    tick();
    pcInc = 1'b0; pcLoad = 1'b0; done = 1'b0;
    if (ld)       exp_pc = val;
    else if (inc) exp_pc = (exp_pc + 1) & 255;
    chk("exec_pc", pc, exp_pc);
  endtask

  task automatic bubble();
    chk("bubble_instr", instruction, 0);
    chk("bubble_req", memReq, 0);
    tick();
    if (!run) begin
      chk("idle_req", memReq, 0);
      chk("idle_instr", instruction, 0);
    end
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  op;
    int          len;

    memData = 16'h0; pcLoadVal = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // MOVi: ack after one wait cycle, done three cycles into EXEC
    mem[0] = 16'h5047; mem[1] = 16'hF000;
    run = 1'b1; tick();
    fetch(1, 0, w); issue(w);
    exec_cycle(w, 0, 0, 0, 0);
    exec_cycle(w, 1, 0, 0, 0);
    exec_cycle(w, 0, 0, 0, 1);
    bubble();
    chk("movi_next_addr", memAddr, 1);
    fetch(0, 0, w); issue(w);

    // Back-to-back identical words
    do_reset();
    mem[0] = 16'h5047; mem[1] = 16'h5047; mem[2] = 16'hF000;
    run = 1'b1; tick();
    for (int k = 0; k < 2; k++) begin
      fetch(0, 0, w); issue(w);
      exec_cycle(w, 0, 0, 0, 0);
      exec_cycle(w, 1, 0, 0, 1);
      bubble();
    end
    chk("b2b_pc", pc, 2);
    fetch(0, 0, w); issue(w);

    // NOP then HALT; stray execution pulses in HALT are ignored
    do_reset();
    mem[0] = 16'h0000; mem[1] = 16'hF000;
    run = 1'b1; tick();
    fetch(0, 0, w); issue(w);
    fetch(0, 0, w); issue(w);
    pcInc = 1'b1; pcLoad = 1'b1; pcLoadVal = 8'h44;
    for (int k = 0; k < 3; k++) tick();
    pcInc = 1'b0; pcLoad = 1'b0;
    chk("halt_pc", pc, 1);
    chk("halt_sticky", halted, 1);
    chk("halt_req_low", memReq, 0);

    // Timeout: 16 EXEC cycles without done -> fault
    do_reset();
    mem[0] = 16'h7123;
    run = 1'b1; tick();
    fetch(0, 0, w); issue(w);
    for (int k = 0; k < 15; k++) exec_cycle(w, 0, 0, 0, 0);
    chk("to_no_fault_15", fault, 0);
    exec_cycle(w, 0, 0, 0, 0);
    chk("to_fault", fault, 1);
    chk("to_fault_instr", instruction, 0);
    chk("to_fault_req", memReq, 0);
    tick();
    chk("to_fault_sticky", fault, 1);

    // done in the 16th cycle wins over the timeout
    do_reset();
    run = 1'b1; tick();
    fetch(0, 0, w); issue(w);
    run = 1'b0;
    for (int k = 0; k < 15; k++) exec_cycle(w, 0, 0, 0, 0);
    exec_cycle(w, 0, 0, 0, 1);
    chk("to_done_fault", fault, 0);
    bubble();

    // Wrap and jump priority
    do_reset();
    mem[0] = 16'h5001;
    run = 1'b1; tick();
    fetch(0, 0, w); issue(w);
    run = 1'b0;
    exec_cycle(w, 0, 1, 8'hFF, 0);
    exec_cycle(w, 1, 0, 0, 0);
    chk("wrap_pc", pc, 8'h00);
    exec_cycle(w, 1, 1, 8'h20, 1);
    chk("jump_pc", pc, 8'h20);
    bubble();

    // Reset mid-EXEC, stray ack afterwards, then a 5-cycle wait-state fetch
    do_reset();
    mem[0] = 16'h7000;
    run = 1'b1; tick();
    fetch(0, 0, w); issue(w);
    exec_cycle(w, 1, 0, 0, 0);
    do_reset();
    chk_all_zero("mid_rst");
    memAck = 1'b1; memData = 16'h5555;
    tick();
    memAck = 1'b0;
    chk("stray_ack_req", memReq, 0);
    chk("stray_ack_instr", instruction, 0);
    mem[0] = 16'h5047;
    run = 1'b1; tick();
    fetch(5, 1, w); issue(w);
    run = 1'b0;
    exec_cycle(w, 0, 0, 0, 1);
    bubble();

    // Randomized program against the instruction-level model
    do_reset();
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 3))
        0:       op = 4'h0;
        1:       op = 4'h5;
        2:       op = 4'h7;
        default: op = 4'($urandom_range(1, 14));
      endcase
      mem[i] = {op, 12'($urandom)};
    end
    run = 1'b1; tick();
    for (int n = 0; n < 40; n++) begin
      fetch($urandom_range(0, 3), 1'($urandom_range(0, 1)), w);
      issue(w);
      if (w[15:12] != 4'h0) begin
        len = $urandom_range(1, 10);
        if (n == 39) run = 1'b0;
        for (int k = 1; k <= len; k++)
          exec_cycle(w, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                     8'($urandom), (k == len));
        bubble();
      end
      if (!run) break;
    end
    if (run) begin
      // last fetched word was a NOP: stop cleanly via one more instruction
      run = 1'b0;
      chk("rnd_tail_req", memReq, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, program-counter and memory-address width.
REQ-002 Parameter TIMEOUT, default 16, maximum EXEC cycles allowed before a fault.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 run  in  1  enable instruction sequencing.
REQ-007 memReq  out  1  instruction-memory read request.
REQ-008 memAddr  out  ADDR_W  read address; equals pc while memReq=1.
REQ-009 memAck  in  1  read data valid this cycle.
REQ-010 memData  in  16  instruction word.
REQ-011 instruction  out  16  word presented to the execution FSMs.
REQ-012 pcInc  in  1  PC-increment pulse from the execution FSMs (OR-combined).
REQ-013 done  in  1  completion pulse from the execution FSMs (OR-combined).
REQ-014 pcLoad  in  1  jump request; pcLoadVal  in  ADDR_W  jump target.
REQ-015 pc  out  ADDR_W  current program counter.
REQ-016 halted  out  1  HALT reached; fault  out  1  execution timeout.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, ISSUE, EXEC, BUBBLE, HALT and FAULT.
REQ-018 IDLE: instruction=0, memReq=0; run=1 -> FETCH on the next edge.
REQ-019 FETCH: memReq=1, memAddr=pc, held until memAck=1; on memAck, capture memData into IR -> ISSUE; memReq=0 from the next cycle.
REQ-020 ISSUE, IR[15:12]=4'h0 (NOP): pc+1 -> FETCH.
REQ-021 ISSUE, IR[15:12]=4'hF: -> HALT.
REQ-022 ISSUE, any other opcode: -> EXEC; clear timeout counter.
REQ-023 EXEC: instruction=IR, held stable for every EXEC cycle.
REQ-024 EXEC, pcInc=1: pc+1, wrapping from all-ones to 0.
REQ-025 EXEC, pcLoad=1: pc=pcLoadVal; pcLoad wins over a simultaneous pcInc.
REQ-026 EXEC, done=1: -> BUBBLE; pcInc/pcLoad in the same cycle are still applied.
REQ-027 EXEC: if the counter reaches TIMEOUT-1 without done -> FAULT; done in that same cycle wins (-> BUBBLE).
REQ-028 BUBBLE: instruction=16'h0000 for exactly one cycle, so the execution FSMs see a non-matching opcode and return to their idle state; then run=1 -> FETCH, run=0 -> IDLE.
REQ-029 HALT: halted=1, instruction=0, memReq=0; held until rst.
REQ-030 FAULT: fault=1, instruction=0, memReq=0; held until rst.
REQ-031 pcInc, pcLoad and done SHALL be ignored outside EXEC; memAck SHALL be ignored outside FETCH.
REQ-032 run=0 during FETCH/ISSUE/EXEC SHALL NOT abort; the current instruction completes and the FSM stops at BUBBLE -> IDLE.
REQ-033 instruction, memReq, memAddr, pc, halted and fault SHALL be registered outputs.

Reset
REQ-034 rst=1 at any edge, including mid-fetch or mid-EXEC: state=IDLE, pc=0, IR=0, instruction=0, memReq=0, memAddr=0, halted=0, fault=0, timeout counter=0.
REQ-035 An outstanding memAck arriving after reset SHALL be ignored.

Structure
REQ-036 Shared package mcu_ctrl_pkg SHALL hold OP_NOP=4'h0, OP_MOVI=4'h5 and OP_HALT=4'hF, the state encoding, and the TIMEOUT default.
REQ-037 The program counter with increment, load and wrap SHALL be sub-module pc_reg; everything else stays in instr_fetch_ctrl.

Verification
REQ-038 MOVi: run=1, mem[0]=16'h5047, ack after 1 cycle; done 3 cycles after EXEC entry -> instruction=16'h5047 throughout EXEC, pc 0->1 on pcInc, one BUBBLE cycle of 16'h0000, then memAddr=1.
REQ-039 Back-to-back identical words: mem[0]=mem[1]=16'h5047 -> a BUBBLE zero cycle between the two EXEC windows; both execute; pc=2.
REQ-040 NOP then HALT: mem[0]=16'h0000, mem[1]=16'hF000 -> no EXEC entry, pc=1, halted=1, memReq stays 0.
REQ-041 Timeout: opcode 4'h7 with done never asserted -> fault=1 after exactly 16 EXEC cycles; a done in the 16th cycle instead gives BUBBLE with fault=0.
REQ-042 Wrap and jump: pc=8'hFF with pcInc -> pc=0x00; pcLoad=1, pcLoadVal=8'h20 and pcInc in the same cycle -> pc=0x20.
REQ-043 Reset mid-EXEC and wait-state fetch: rst during EXEC -> all outputs 0 next cycle; memAck delayed 5 cycles -> memReq held steady for all 5 cycles.
